// File: rtl/piso_serializer.sv
`timescale 1ns/1ps
// Parallel-in / serial-out stage: accepts an n-bit word over a valid/ready load
// handshake, shifts it out LSB first, then pulses done. Define PISO_PARITY_EN to
// append the even-parity bit of the latched word after the data bits.
module piso_serializer #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [n-1:0] d,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int cnt_n = (n > 2) ? $clog2(n) : 1;
  localparam logic [cnt_n-1:0] CNT_LAST = cnt_n'(n - 1);

  // Handshake: a word transfers on a posedge where load_valid && load_ready;
  // load_ready is high only in IDLE and only while en is high.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef PISO_PARITY_EN
    ,PAR  = 2'd3
`endif
  } state_t;

  state_t           state_q;
  logic [n-1:0]     shreg_q;
  logic [cnt_n-1:0] cnt_q;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shreg_q <= d;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= ^d;
`endif
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q <= {1'b0, shreg_q[n-1:1]};
          // cnt saturates at n-1 so it never wraps; the next accept clears it.
          if (cnt_q == CNT_LAST) begin
`ifdef PISO_PARITY_EN
            state_q <= PAR;
`else
            state_q <= DONE;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef PISO_PARITY_EN
        PAR:  state_q <= DONE;
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode from registers; only load_ready sees an input (en).
  always_comb begin
    load_ready = en && (state_q == IDLE);
    done       = (state_q == DONE);
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    if (state_q == SHIFT) begin
      ser_valid = 1'b1;
      ser_out   = shreg_q[0];
    end
`ifdef PISO_PARITY_EN
    if (state_q == PAR) begin
      ser_valid = 1'b1;
      ser_out   = par_q;
    end
`endif
    busy      = ser_valid;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
`timescale 1ns/1ps
// Bench for piso_serializer: directed scenarios plus random frames, n=8 and n=4
// instances, expected bit stream built from the word's bit positions.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // n=8 instance
  logic       en, load_valid, load_ready, ser_out, ser_valid, busy, done;
  logic [7:0] d;
  logic [1:0] dbg8;

  // n=4 instance
  logic       en4, lv4, ready4, ser_out4, ser_valid4, busy4, done4;
  logic [3:0] d4;
  logic [1:0] dbg4;

  piso_serializer #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .d(d), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done),
    .dbg_state(dbg8)
  );

  piso_serializer #(.n(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .load_valid(lv4), .load_ready(ready4),
    .d(d4), .ser_out(ser_out4), .ser_valid(ser_valid4), .busy(busy4), .done(done4),
    .dbg_state(dbg4)
  );

  // scoreboard
  int n_pass   = 0;
  int n_checks = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one n=8 frame; stall_at>=0 forces 3 en=0 cycles after that many bits.
  task automatic run_frame(input logic [7:0] dv, input int stall_pct, input bit poke,
                           input int stall_at, output int bit_cycles, output int total);
    int popped;
    int stall_left;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(dv[i]);
    if (PB == 1) exp_q.push_back(^dv);
    en = 1'b1; d = dv; load_valid = 1'b1;
    #1;
    chk("ready_idle", load_ready, 1);
    tick();
    load_valid = 1'b0;
    total = 1; bit_cycles = 0; popped = 0; stall_left = 3;
    while (exp_q.size() > 0 && bit_cycles < 100) begin
      chk("ser_valid", ser_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("ready_busy", load_ready, 0);
      chk("ser_out", ser_out, exp_q[0]);
      if (popped == stall_at && stall_left > 0) begin
        en = 1'b0;
        stall_left--;
      end else begin
        en = ($urandom_range(0, 99) >= stall_pct);
      end
      if (poke) begin
        load_valid = 1'b1;
        d = 8'hFF;
      end
      tick();
      bit_cycles++; total++;
      if (en) begin
        void'(exp_q.pop_front());
        popped++;
      end
    end
    chk("frame_bounded", exp_q.size(), 0);
    load_valid = 1'b0; en = 1'b1;
    #1;
    chk("done_pulse", done, 1);
    chk("done_ser_valid", ser_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_ready", load_ready, 0);
    tick();
    total++;
    chk("done_cleared", done, 0);
    chk("ready_again", load_ready, 1);
  endtask

  task automatic run4(input logic [3:0] dv, output int total);
    logic [0:0] q4[$];
    for (int i = 0; i < 4; i++) q4.push_back(dv[i]);
    if (PB == 1) q4.push_back(^dv);
    en4 = 1'b1; d4 = dv; lv4 = 1'b1;
    #1;
    chk("n4_ready", ready4, 1);
    tick();
    lv4 = 1'b0;
    total = 1;
    while (q4.size() > 0 && total < 50) begin
      chk("n4_ser_valid", ser_valid4, 1);
      chk("n4_ser_out", ser_out4, q4.pop_front());
      tick();
      total++;
    end
    chk("n4_done", done4, 1);
    tick();
    total++;
    chk("n4_ready_again", ready4, 1);
  endtask

  initial begin
    int bc, tot;
    rst = 1'b0; en = 1'b0; load_valid = 1'b0; d = '0;
    en4 = 1'b0; lv4 = 1'b0; d4 = '0;

    // reset state
    #12;
    chk("rst_ser_out", ser_out, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready_en0", load_ready, 0);
    en = 1'b1;
    #1;
    chk("rst_ready_en1", load_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // basic frame, then ignored load during a frame
    run_frame(8'hA5, 0, 1'b0, -1, bc, tot);
    chk("a5_spacing", tot, 10 + PB);
    run_frame(8'hA5, 0, 1'b1, -1, bc, tot);
    chk("poke_spacing", tot, 10 + PB);

    // idle with en low
    en = 1'b0;
    #1;
    chk("idle_ready_en0", load_ready, 0);

    // enable stall after the 3rd bit
    run_frame(8'h3C, 0, 1'b0, 3, bc, tot);
    chk("stall_bit_cycles", bc, 11 + PB);

    // parity-relevant words
    run_frame(8'h07, 0, 1'b0, -1, bc, tot);
    run_frame(8'h03, 0, 1'b0, -1, bc, tot);
    run_frame(8'h00, 0, 1'b0, -1, bc, tot);
    run_frame(8'hFF, 0, 1'b0, -1, bc, tot);

    // random words, random stalls, random pokes
    for (int k = 0; k < 20; k++) begin
      run_frame(8'($urandom), 25, bit'($urandom_range(0, 1)), -1, bc, tot);
    end

    // reset mid-frame
    en = 1'b1; d = 8'hF0; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    chk("mid_busy_before", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ser_valid", ser_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_ser_out", ser_out, 0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_abort_done", done, 0);
      chk("post_abort_ready", load_ready, 1);
      chk("post_abort_valid", ser_valid, 0);
    end
    run_frame(8'h5A, 0, 1'b0, -1, bc, tot);

    // n=4 width scaling, back-to-back
    run4(4'b1001, tot);
    chk("n4_spacing", tot, 6 + PB);
    run4(4'($urandom), tot);
    chk("n4_spacing2", tot, 6 + PB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
